// File: rtl/sha256_padder_if.sv
// sha256_padder_if: message-word stream in, padded-word FIFO writes out.
//   in_vld_i/in_rdy_o/in_dat_i : message-word handshake, big-endian bytes
//   fifo_full_i                : downstream programmable-full
//   fifo_wr_en_o/fifo_wr_dat_o : registered FIFO write strobe and data
interface sha256_padder_if;
  logic        in_vld_i;
  logic        in_rdy_o;
  logic [31:0] in_dat_i;
  logic        fifo_full_i;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_wr_dat_o;
  modport master (output in_vld_i, in_dat_i, fifo_full_i, input in_rdy_o, fifo_wr_en_o, fifo_wr_dat_o);
  modport slave  (input in_vld_i, in_dat_i, fifo_full_i, output in_rdy_o, fifo_wr_en_o, fifo_wr_dat_o);
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: SHA-256 message padder emitting 32-bit words into a FIFO.
//   clk_i, rstn_i         : clock, async active-low reset
//   start_i, bit_len_i    : start a message of bit_len_i bits (IDLE only)
//   bus (slave)           : message-word stream and FIFO write port
//   ready_o, busy_o       : idle / message in progress
//   done_o                : one-cycle pulse after the length word is written
//   err_o                 : sticky, start rejected for non-byte length
//   blk_cnt_o             : 512-bit blocks emitted (only with SHA256_PAD_BLKCNT_EN)
module sha256_padder (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [31:0] bit_len_i,
  sha256_padder_if.slave bus,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [15:0] blk_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, DATA, PAD80, ZERO, LEN_HI, LEN_LO} state_t;
  state_t      state_q, state_d, tail_st;
  logic [31:0] len_q, len_d, wr_dat_q, wr_dat_d, fin_dat;
  logic [27:0] rem_q, rem_d, ndw;
  logic [3:0]  widx_q, widx_d;
  logic        wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
  logic        go, last, len_ok;
  assign len_ok  = ~|bit_len_i[2:0];
  assign ndw     = {1'b0, bit_len_i[31:5]} + 28'(|bit_len_i[4:3]);
  assign last    = rem_q == 28'd1;
  // once the 0x80 byte is out, zero-fill until the length occupies slots 14/15
  assign tail_st = widx_q == 4'd13 ? LEN_HI : ZERO;
  // final data word keeps only its valid bytes and appends the 0x80 marker
  assign fin_dat = len_q[4:3] == 2'd1 ? {bus.in_dat_i[31:24], 24'h800000} :
                   len_q[4:3] == 2'd2 ? {bus.in_dat_i[31:16], 16'h8000} :
                   len_q[4:3] == 2'd3 ? {bus.in_dat_i[31:8], 8'h80} : bus.in_dat_i;
  // a word is produced this cycle only while the FIFO has room
  assign go = !bus.fifo_full_i && (state_q == DATA ? bus.in_vld_i : state_q != IDLE);
  assign bus.in_rdy_o      = state_q == DATA && !bus.fifo_full_i;
  assign bus.fifo_wr_en_o  = wr_en_q;
  assign bus.fifo_wr_dat_o = wr_dat_q;
  assign ready_o = state_q == IDLE;
  assign busy_o  = state_q != IDLE;
  assign done_o  = done_q;
  assign err_o   = err_q;
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rem_d    = rem_q;
    widx_d   = go ? widx_q + 4'd1 : widx_q;
    wr_en_d  = go;
    wr_dat_d = wr_dat_q;
    // the length word's strobe is visible in the first IDLE cycle
    done_d   = wr_en_q && state_q == IDLE;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        err_d = !len_ok;
        if (len_ok) begin
          len_d   = bit_len_i;
          rem_d   = ndw;
          widx_d  = 4'd0;
          state_d = ndw != 28'd0 ? DATA : PAD80;
        end
      end
      DATA: if (go) begin
        rem_d    = rem_q - 28'd1;
        wr_dat_d = last ? fin_dat : bus.in_dat_i;
        if (last) state_d = len_q[4:3] == 2'd0 ? PAD80 : tail_st;
      end
      PAD80: if (go) begin
        wr_dat_d = 32'h80000000;
        state_d  = tail_st;
      end
      ZERO: if (go) begin
        wr_dat_d = 32'h0;
        state_d  = tail_st;
      end
      LEN_HI: if (go) begin
        wr_dat_d = 32'h0;
        state_d  = LEN_LO;
      end
      LEN_LO: if (go) begin
        wr_dat_d = len_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      widx_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_dat_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      widx_q   <= widx_d;
      wr_en_q  <= wr_en_d;
      wr_dat_q <= wr_dat_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] blk_q, blk_d;
  assign blk_cnt_o = blk_q;
  // a write in slot 15 closes a 512-bit block
  always_comb
    blk_d = (state_q == IDLE && start_i && len_ok) ? 16'd0 :
            (go && widx_q == 4'd15 && blk_q != 16'hFFFF) ? blk_q + 16'd1 : blk_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) blk_q <= '0;
    else blk_q <= blk_d;
`endif
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed vectors for sha256_padder with hand-computed words.
module tb_sha256_padder;
  logic clk = 0, rstn = 0, start = 0;
  logic [31:0] bit_len = 0;
  logic ready, busy, done, err;
  logic [15:0] blk_cnt;
  sha256_padder_if bus();
  sha256_padder dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .bit_len_i(bit_len), .bus(bus),
    .ready_o(ready), .busy_o(busy), .done_o(done), .err_o(err)
`ifdef SHA256_PAD_BLKCNT_EN
    , .blk_cnt_o(blk_cnt)
`endif
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0, done_cnt = 0;
  logic done_prev = 0, full_prev = 0, rdy_seen = 0, tog = 0;
  logic [31:0] got[$], din[$], exp_q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, req);
    end
  endtask
  always @(negedge clk) begin
    if (bus.fifo_wr_en_o) begin
      got.push_back(bus.fifo_wr_dat_o);
      chk("wr_while_full", 32'(full_prev), 32'd0);
    end
    if (bus.in_rdy_o) rdy_seen = 1;
    if (done) begin
      done_cnt++;
      chk("done_width", 32'(done_prev), 32'd0);
    end
    done_prev = done;
    full_prev = bus.fifo_full_i;
  end
  initial begin
    int tc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tog) begin
        tc++;
        if (tc % 3 == 0) bus.fifo_full_i = !bus.fifo_full_i;
      end
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic zeros(input int n);
    repeat (n) exp_q.push_back(32'h0);
  endtask
  task automatic do_start(input logic [31:0] len);
    start = 1;
    bit_len = len;
    cycles(1);
    start = 0;
  endtask
  task automatic send();
    for (int i = 0; i < din.size(); i++) begin
      logic acc = 0;
      bus.in_vld_i = 1;
      bus.in_dat_i = din[i];
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk);
        acc = bus.in_rdy_o;
        @(posedge clk);
        #1;
      end
      if (!acc) chk("rdy_timeout", 32'd0, 32'd1);
    end
    bus.in_vld_i = 0;
    bus.in_dat_i = 0;
  endtask
  task automatic run(input string tag, input logic [31:0] len);
    int d0 = done_cnt;
    got.delete();
    do_start(len);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    send();
    for (int c = 0; c < 600 && done_cnt == d0; c++) cycles(1);
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_idle"}, {30'd0, busy, ready}, 32'd1);
  endtask
  task automatic blk(input string tag, input logic [15:0] n);
`ifdef SHA256_PAD_BLKCNT_EN
    chk({tag, "_blk"}, 32'(blk_cnt), 32'(n));
`endif
  endtask
  task automatic t_24(input string tag);
    din = '{32'h61626364};
    exp_q = '{32'h61626380};
    zeros(14);
    exp_q.push_back(32'h18);
    run(tag, 32'd24);
    blk(tag, 16'd1);
  endtask
  initial begin
    bus.in_vld_i = 0;
    bus.in_dat_i = 0;
    bus.fifo_full_i = 0;
    cycles(3);
    chk("rst_outs", {26'd0, bus.fifo_wr_en_o, bus.in_rdy_o, busy, done, err, ready}, 32'd1);
    chk("rst_dat", bus.fifo_wr_dat_o, 32'd0);
    rstn = 1;
    cycles(2);
    chk("post_rst_ready", 32'(ready), 32'd1);
    blk("rst", 16'd0);
    t_24("len24");
    din.delete();
    rdy_seen = 0;
    exp_q = '{32'h80000000};
    zeros(15);
    run("len0", 32'd0);
    chk("len0_no_rdy", 32'(rdy_seen), 32'd0);
    blk("len0", 16'd1);
    din.delete();
    for (int i = 0; i < 14; i++) din.push_back(32'hA0000000 + i);
    exp_q = din;
    exp_q.push_back(32'h80000000);
    zeros(16);
    exp_q.push_back(32'h1C0);
    run("len448", 32'd448);
    blk("len448", 16'd2);
    din.delete();
    for (int i = 0; i < 16; i++) din.push_back(32'hB0000000 + i);
    exp_q = din;
    exp_q.push_back(32'h80000000);
    zeros(14);
    exp_q.push_back(32'h200);
    tog = 1;
    run("len512_full", 32'd512);
    tog = 0;
    bus.fifo_full_i = 0;
    blk("len512_full", 16'd2);
    din = '{32'hAABBCCDD, 32'h11223344};
    exp_q = '{32'hAABBCCDD, 32'h11800000};
    zeros(13);
    exp_q.push_back(32'h28);
    run("len40", 32'd40);
    din = '{32'hDEADBEEF};
    exp_q = '{32'hDEAD8000};
    zeros(14);
    exp_q.push_back(32'h10);
    run("len16", 32'd16);
    din.delete();
    for (int i = 0; i < 13; i++) din.push_back(32'hC0000000 + i);
    din.push_back(32'h41424344);
    exp_q = din;
    exp_q[13] = 32'h41424380;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1B8);
    run("len440", 32'd440);
    blk("len440", 16'd1);
    got.delete();
    do_start(32'd25);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_state", {30'd0, busy, ready}, 32'd1);
    cycles(5);
    chk("bad_nowr", 32'(got.size()), 32'd0);
    chk("bad_sticky", 32'(err), 32'd1);
    din = '{32'h7A5A5A5A};
    exp_q = '{32'h7A800000};
    zeros(14);
    exp_q.push_back(32'h8);
    run("len8", 32'd8);
    chk("len8_err_clr", 32'(err), 32'd0);
    din.delete();
    for (int i = 0; i < 5; i++) din.push_back(32'hD0000000 + i);
    do_start(32'd512);
    send();
    rstn = 0;
    #1;
    chk("mid_rst_outs", {26'd0, bus.fifo_wr_en_o, bus.in_rdy_o, busy, done, err, 1'b0}, 32'd0);
    chk("mid_rst_dat", bus.fifo_wr_dat_o, 32'd0);
    blk("mid_rst", 16'd0);
    cycles(1);
    rstn = 1;
    got.delete();
    cycles(5);
    chk("mid_rst_nowr", 32'(got.size()), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    t_24("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rstn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start_i  in  1  begin new message; sampled only in IDLE.
REQ-004 SHALL have: bit_len_i  in  32  message length in bits, latched at accepted start.
REQ-005 SHALL have: in_vld_i / in_rdy_o  in/out  1/1  message-word handshake, transfer when both high.
REQ-006 SHALL have: in_dat_i  in  32  message word, big-endian byte order (byte 0 = bits 31:24).
REQ-007 SHALL have: fifo_full_i  in  1  downstream FIFO programmable-full, asserts with >=2 free entries.
REQ-008 SHALL have: fifo_wr_en_o / fifo_wr_dat_o  out  1/32  registered FIFO write strobe and data.
REQ-009 SHALL have: ready_o  out  1  high in IDLE only.
REQ-010 SHALL have: busy_o  out  1  high from accepted start through final length word; drives engine dma_in_progress_i.
REQ-011 SHALL have: done_o  out  1  one-cycle pulse after last word written.
REQ-012 SHALL have: err_o  out  1  sticky: start rejected because bit_len_i[2:0] != 0.

Function
REQ-013 States SHALL be IDLE, DATA, PAD80, ZERO, LEN_HI, LEN_LO.
REQ-014 IDLE: start_i with bit_len_i[2:0]==0 SHALL latch length, clear err_o, set word index widx=0, data count ndw = bit_len[31:5] + |bit_len[4:3], go DATA (ndw>0) or PAD80 (ndw==0).
REQ-015 IDLE: start_i with bit_len_i[2:0]!=0 SHALL set err_o, stay IDLE; err_o clears on next accepted start.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 in_rdy_o SHALL equal (state==DATA) && !fifo_full_i; no write issued in any state while fifo_full_i high.
REQ-018 Each write SHALL be a registered single-cycle fifo_wr_en_o pulse, 1-cycle latency from input transfer; widx (4 bit) increments mod 16 per write.
REQ-019 DATA: non-final words SHALL pass unchanged; final word with len[4:3]=1/2/3 SHALL be {B0,80,00,00}/{B0,B1,80,00}/{B0,B1,B2,80}, discarding unused input bytes, then go ZERO or LEN_HI.
REQ-020 DATA: final word with len[4:3]==0 SHALL pass unchanged, go PAD80.
REQ-021 PAD80 SHALL write 32'h80000000 once.
REQ-022 After 0x80-bearing word: if next widx==14 go LEN_HI, else ZERO.
REQ-023 ZERO SHALL write 32'h00000000 until next widx==14 (wraps into a new block if needed), then LEN_HI.
REQ-024 LEN_HI SHALL write 32'h00000000; LEN_LO SHALL write latched bit_len, pulse done_o next cycle, return IDLE.
REQ-025 Total words written SHALL always be a multiple of 16.
REQ-026 fifo_full_i rising mid-message SHALL stall without loss or duplication; resume on deassert.

Reset
REQ-027 rstn_i low SHALL immediately force IDLE; fifo_wr_en_o, in_rdy_o, busy_o, done_o, err_o = 0, fifo_wr_dat_o = 0, widx = 0, counters 0; ready_o = 1 after release.
REQ-028 Reset mid-message SHALL abandon the message; no further writes until new start.

Configuration
REQ-029 Macro SHA256_PAD_BLKCNT_EN defined: SHALL add output blk_cnt_o[15:0], count of 512-bit blocks emitted for current message, cleared at accepted start, incremented on each write with widx==15, saturating at 16'hFFFF, reset 0.
REQ-030 Macro undefined: blk_cnt_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 bit_len=24, in 0x61626364 -> writes 0x61626380, 13x0, 0x0, 0x00000018; done_o pulse; blk_cnt_o=1.
REQ-032 bit_len=0, no input -> 0x80000000, 13x0, 0x0, 0x0; in_rdy_o never high.
REQ-033 bit_len=448, 14 words -> 14 data, 0x80000000, 15x0, 0x0, 0x000001C0 (32 words); blk_cnt_o=2.
REQ-034 bit_len=512 with fifo_full_i toggled every 3 cycles -> identical 32-word sequence, no writes while full.
REQ-035 bit_len=25 -> err_o=1, state stays IDLE, no writes; next start bit_len=8 clears err_o.
REQ-036 rstn_i low after 5 data words -> outputs at reset values next cycle; new start bit_len=24 produces REQ-031 sequence.
